// File: rtl/clock_divider_prog_if.sv
//-----------------------------------------------------------------------------
// clock_divider_prog_if : control/status bundle of the programmable divider
// Rev 1.0
//-----------------------------------------------------------------------------
`default_nettype none

interface clock_divider_prog_if #(
   parameter int CNT_W = 16
);
   logic             enable;
   logic             sync_clr;
   logic [CNT_W-1:0] div_in;
   logic             div_load;
   logic             div_ack;
   logic [CNT_W-1:0] div_cur;
   logic             clk_out;
   logic             tick;

   modport master (
      output enable, sync_clr, div_in, div_load,
      input  div_ack, div_cur, clk_out, tick
   );

   modport slave (
      input  enable, sync_clr, div_in, div_load,
      output div_ack, div_cur, clk_out, tick
   );
endinterface

`default_nettype wire

// File: rtl/clock_divider_prog.sv
//-----------------------------------------------------------------------------
// clock_divider_prog : runtime-programmable integer clock divider with tick
// Rev 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module clock_divider_prog #(
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 4
) (
   input  wire logic          clk_in,
   input  wire logic          reset_n,
   clock_divider_prog_if.slave bus
);

   localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_TWO     = CNT_W'(2);
   localparam logic [CNT_W-1:0] c_DEF_DIV = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W:0]   c_ONE_W   = (CNT_W+1)'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_cur_q, div_cur_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic             pend_vld_q, pend_vld_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             ack_q, ack_d;

   logic             w_wrap;
   logic             w_apply;
   logic [CNT_W-1:0] w_load_val;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [CNT_W:0]   w_half;

   always_comb begin
      w_wrap     = (cnt_q == (div_cur_q - c_ONE));
      w_apply    = bus.sync_clr | (bus.enable & w_wrap);
      w_load_val = (bus.div_in < c_TWO) ? c_TWO : bus.div_in;
      w_cnt_inc  = w_wrap ? '0 : (cnt_q + c_ONE);
      // High-phase length; one extra bit so the +1 cannot overflow at max divisor.
      w_half     = ({1'b0, div_cur_q} + c_ONE_W) >> 1;

      cnt_d      = cnt_q;
      div_cur_d  = div_cur_q;
      pend_div_d = pend_div_q;
      pend_vld_d = pend_vld_q;
      clk_out_d  = clk_out_q;
      tick_d     = 1'b0;
      ack_d      = 1'b0;

      if (bus.div_load) begin
         pend_div_d = w_load_val;
         pend_vld_d = 1'b1;
      end

      // A load arriving on the apply edge itself bypasses the pending register.
      if (w_apply) begin
         if (bus.div_load) begin
            div_cur_d = w_load_val;
            ack_d     = 1'b1;
         end else if (pend_vld_q) begin
            div_cur_d = pend_div_q;
            ack_d     = 1'b1;
         end
         pend_vld_d = 1'b0;
      end

      if (bus.sync_clr) begin
         cnt_d     = '0;
         tick_d    = 1'b1;
         clk_out_d = 1'b1;
      end else if (bus.enable) begin
         cnt_d     = w_cnt_inc;
         tick_d    = (w_cnt_inc == '0);
         clk_out_d = ({1'b0, w_cnt_inc} < w_half);
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= c_DEF_DIV - c_ONE;
         div_cur_q  <= c_DEF_DIV;
         pend_div_q <= c_DEF_DIV;
         pend_vld_q <= 1'b0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_cur_q  <= div_cur_d;
         pend_div_q <= pend_div_d;
         pend_vld_q <= pend_vld_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
         ack_q      <= ack_d;
      end
   end

   assign bus.div_ack = ack_q;
   assign bus.div_cur = div_cur_q;
   assign bus.clk_out = clk_out_q;
   assign bus.tick    = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
//-----------------------------------------------------------------------------
// tb_clock_divider_prog : directed vector bench for clock_divider_prog
// Rev 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module tb_clock_divider_prog;

   localparam int CNT_W = 16;

   typedef struct {
      logic             en;
      logic             clr;
      logic             ld;
      logic [CNT_W-1:0] din;
      logic             e_tick;
      logic             e_clk;
      logic             e_ack;
      logic [CNT_W-1:0] e_div;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;
   vec_t vecs[$];

   clock_divider_prog_if #(.CNT_W(CNT_W)) bus ();

   clock_divider_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
      .clk_in  (clk),
      .reset_n (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk4(input string name, input logic t, input logic c, input logic a,
                       input logic [CNT_W-1:0] d);
      check({name, ".tick"},    32'(bus.tick),    32'(t));
      check({name, ".clk_out"}, 32'(bus.clk_out), 32'(c));
      check({name, ".div_ack"}, 32'(bus.div_ack), 32'(a));
      check({name, ".div_cur"}, 32'(bus.div_cur), 32'(d));
   endtask

   // Inputs change on the falling edge; outputs are sampled on the next one.
   task automatic drive(input logic en, input logic clr, input logic ld,
                        input logic [CNT_W-1:0] din);
      bus.enable   = en;
      bus.sync_clr = clr;
      bus.div_load = ld;
      bus.div_in   = din;
      @(negedge clk);
   endtask

   function automatic void add(input logic en, input logic clr, input logic ld,
                               input int din, input logic t, input logic c,
                               input logic a, input int d);
      vec_t v;
      v.en = en; v.clr = clr; v.ld = ld; v.din = CNT_W'(din);
      v.e_tick = t; v.e_clk = c; v.e_ack = a; v.e_div = CNT_W'(d);
      vecs.push_back(v);
   endfunction

   initial begin
      n_chk  = 0;
      n_pass = 0;

      // Divide-by-4 from reset: tick every 4, clk_out 1,1,0,0.
      add(1,0,0,0, 1,1,0,4); add(1,0,0,0, 0,1,0,4);
      add(1,0,0,0, 0,0,0,4); add(1,0,0,0, 0,0,0,4);
      add(1,0,0,0, 1,1,0,4); add(1,0,0,0, 0,1,0,4);
      // Load 7 at cnt=1; applies on the next wrap.
      add(1,0,1,7, 0,0,0,4); add(1,0,0,0, 0,0,0,4);
      add(1,0,0,0, 1,1,1,7);
      add(1,0,0,0, 0,1,0,7); add(1,0,0,0, 0,1,0,7); add(1,0,0,0, 0,1,0,7);
      add(1,0,0,0, 0,0,0,7); add(1,0,0,0, 0,0,0,7); add(1,0,0,0, 0,0,0,7);
      add(1,0,0,0, 1,1,0,7);
      // Load 0 then 1: clamped to 2.
      add(1,0,1,0, 0,1,0,7); add(1,0,1,1, 0,1,0,7);
      add(1,0,0,0, 0,1,0,7); add(1,0,0,0, 0,0,0,7);
      add(1,0,0,0, 0,0,0,7); add(1,0,0,0, 0,0,0,7);
      add(1,0,0,0, 1,1,1,2);
      add(1,0,0,0, 0,0,0,2); add(1,0,0,0, 1,1,0,2);
      add(1,0,0,0, 0,0,0,2); add(1,0,0,0, 1,1,0,2);
      // Load 5 pending, then 9 on the wrap edge: single ack, 9 wins.
      add(1,0,1,5, 0,0,0,2); add(1,0,1,9, 1,1,1,9);
      add(1,0,0,0, 0,1,0,9); add(1,0,0,0, 0,1,0,9);
      add(1,0,0,0, 0,1,0,9); add(1,0,0,0, 0,1,0,9);
      add(1,0,0,0, 0,0,0,9); add(1,0,0,0, 0,0,0,9);
      add(1,0,0,0, 0,0,0,9); add(1,0,0,0, 0,0,0,9);
      add(1,0,0,0, 1,1,0,9);
      // Loads 5 then 9 both mid-period: one ack at wrap.
      add(1,0,1,5, 0,1,0,9); add(1,0,1,9, 0,1,0,9);
      add(1,0,0,0, 0,1,0,9); add(1,0,0,0, 0,1,0,9);
      add(1,0,0,0, 0,0,0,9); add(1,0,0,0, 0,0,0,9);
      add(1,0,0,0, 0,0,0,9); add(1,0,0,0, 0,0,0,9);
      add(1,0,0,0, 1,1,1,9); add(1,0,0,0, 0,1,0,9);

      rst_n        = 1'b0;
      bus.enable   = 1'b0;
      bus.sync_clr = 1'b0;
      bus.div_load = 1'b0;
      bus.div_in   = '0;
      @(negedge clk);
      bus.enable = 1'b1;
      @(negedge clk);
      chk4("reset", 0, 0, 0, 4);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].en, vecs[i].clr, vecs[i].ld, vecs[i].din);
         chk4($sformatf("vec%0d", i), vecs[i].e_tick, vecs[i].e_clk,
              vecs[i].e_ack, vecs[i].e_div);
      end

      // Freeze mid-period (cnt=3 of 9) with a load captured while frozen.
      drive(1,0,0,0); chk4("pre_frz_a", 0, 1, 0, 9);
      drive(1,0,0,0); chk4("pre_frz_b", 0, 1, 0, 9);
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, (i == 3), 3);
         chk4($sformatf("frz%0d", i), 0, 1, 0, 9);
      end
      drive(1,0,0,0); chk4("resume4", 0, 1, 0, 9);
      for (int i = 5; i < 9; i++) begin
         drive(1,0,0,0);
         chk4($sformatf("resume%0d", i), 0, 0, 0, 9);
      end
      drive(1,0,0,0); chk4("frz_apply", 1, 1, 1, 3);
      drive(1,0,0,0); chk4("div3_c1", 0, 1, 0, 3);

      // sync_clr mid-period, then sync_clr with enable=0 applies a pending load.
      drive(1,1,0,0); chk4("sclr", 1, 1, 0, 3);
      drive(1,0,0,0); chk4("sclr_c1", 0, 1, 0, 3);
      drive(1,0,0,0); chk4("sclr_c2", 0, 0, 0, 3);
      drive(0,0,1,6); chk4("ld_frz", 0, 0, 0, 3);
      drive(0,1,0,0); chk4("sclr_apply", 1, 1, 1, 6);
      drive(1,0,0,0); chk4("div6_c1", 0, 1, 0, 6);
      drive(1,0,1,5); chk4("div6_c2", 0, 1, 0, 6);
      bus.div_load = 1'b0;

      // Asynchronous reset mid-period with a load pending.
      #3 rst_n = 1'b0;
      #1 chk4("async_rst", 0, 0, 0, 4);
      @(negedge clk);
      chk4("rst_hold", 0, 0, 0, 4);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(1,0,0,0);
         chk4($sformatf("post_rst%0d", i), (i % 4 == 0), (i % 4 < 2), 0, 4);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
